// File: rtl/issue_dispatch_unit_pkg.sv
// Shared constants for the issue/dispatch block: unit indices, default widths,
// and the one-hot select check.
package issue_dispatch_unit_pkg;

    localparam int UNIT_INT  = 0;
    localparam int UNIT_VEC  = 1;
    localparam int UNIT_LSU  = 2;

    localparam int DEF_UOP_W = 4;
    localparam int DEF_CNT_W = 16;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/issue_dispatch_unit_issue_slot.sv
// One-entry dispatch slot for a single execution unit, plus its drain counter.
module issue_slot
    import issue_dispatch_unit_pkg::*;
#(
    parameter int UOP_W = DEF_UOP_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             flush_in,
    input  logic             load_in,
    input  logic [UOP_W-1:0] uop_in,
    input  logic             ready_in,
    output logic             slot_ready_out,
    output logic             valid_out,
    output logic [UOP_W-1:0] uop_out,
    output logic [CNT_W-1:0] cnt_out
);

    logic             valid_r;
    logic [UOP_W-1:0] uop_r;
    logic [CNT_W-1:0] cnt_r;
    logic             drain_s;

    assign drain_s        = valid_r && ready_in;
    assign slot_ready_out = !valid_r || ready_in;
    assign valid_out      = valid_r;
    assign uop_out        = uop_r;
    assign cnt_out        = cnt_r;

    // Slot payload: the micro-op is zeroed whenever the slot is empty
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            valid_r <= 1'b0;
            uop_r   <= {UOP_W{1'b0}};
        end else if (flush_in) begin
            valid_r <= 1'b0;
            uop_r   <= {UOP_W{1'b0}};
        end else if (load_in) begin
            valid_r <= 1'b1;
            uop_r   <= uop_in;
        end else if (drain_s) begin
            valid_r <= 1'b0;
            uop_r   <= {UOP_W{1'b0}};
        end else begin
            valid_r <= valid_r;
            uop_r   <= uop_r;
        end
    end

    // Drain counter survives flush; a drain in the flush cycle still counts
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (drain_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/issue_dispatch_unit.sv
// Issue/dispatch: routes one-hot-selected micro-ops into per-unit one-entry slots.
// Optional sticky illegal-select flag enabled by macro ISSUE_ILLEGAL_SEL_DETECT_EN.
module issue_dispatch_unit
    import issue_dispatch_unit_pkg::*;
#(
    parameter int NUM_UNITS = 3,
    parameter int UOP_W     = DEF_UOP_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                       clock_in,
    input  logic                       reset_in,
    input  logic                       flush_in,
    input  logic                       issue_valid_in,
    output logic                       issue_ready_out,
    input  logic [NUM_UNITS-1:0]       exec_unit_sel_in,
    input  logic [UOP_W-1:0]           exec_uop_in,
    output logic [NUM_UNITS-1:0]       unit_valid_out,
    input  logic [NUM_UNITS-1:0]       unit_ready_in,
    output logic [NUM_UNITS*UOP_W-1:0] unit_uop_out,
    output logic [NUM_UNITS*CNT_W-1:0] unit_issue_cnt_out,
    output logic                       illegal_sel_out
);

    logic [7:0]           sel_ext;
    logic                 sel_legal;
    logic                 sel_ready;
    logic                 accept;
    logic [NUM_UNITS-1:0] slot_ready;
    logic [NUM_UNITS-1:0] load;

    // Widen the select so the one-hot check works for any unit count
    always_comb begin
        sel_ext                  = 8'd0;
        sel_ext[NUM_UNITS-1:0]   = exec_unit_sel_in;
    end

    assign sel_legal = is_onehot8(sel_ext);
    assign sel_ready = |(exec_unit_sel_in & slot_ready);

    // Illegal selects are always swallowed, so they see ready unless flushing
    always_comb begin
        issue_ready_out = 1'b0;
        if (flush_in) begin
            issue_ready_out = 1'b0;
        end else if (!sel_legal) begin
            issue_ready_out = 1'b1;
        end else begin
            issue_ready_out = sel_ready;
        end
    end

    assign accept = issue_valid_in && issue_ready_out && sel_legal;
    assign load   = accept ? exec_unit_sel_in : {NUM_UNITS{1'b0}};

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_slot
        issue_slot #(
            .UOP_W (UOP_W),
            .CNT_W (CNT_W)
        ) u_slot (
            .clock_in       (clock_in),
            .reset_in       (reset_in),
            .flush_in       (flush_in),
            .load_in        (load[k]),
            .uop_in         (exec_uop_in),
            .ready_in       (unit_ready_in[k]),
            .slot_ready_out (slot_ready[k]),
            .valid_out      (unit_valid_out[k]),
            .uop_out        (unit_uop_out[k*UOP_W +: UOP_W]),
            .cnt_out        (unit_issue_cnt_out[k*CNT_W +: CNT_W])
        );
    end

`ifdef ISSUE_ILLEGAL_SEL_DETECT_EN
    logic illegal_r;

    // Sticky flag: set on an offered illegal select, cleared by flush
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            illegal_r <= 1'b0;
        end else if (flush_in) begin
            illegal_r <= 1'b0;
        end else if (issue_valid_in && !sel_legal) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal_sel_out = illegal_r;
`else
    assign illegal_sel_out = 1'b0;
`endif

endmodule

// File: tb/tb_issue_dispatch_unit.sv
// Scoreboard bench for issue_dispatch_unit (NUM_UNITS=3, UOP_W=4, CNT_W=2).
module tb_issue_dispatch_unit;

`ifdef ISSUE_ILLEGAL_SEL_DETECT_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        issue_valid_in = 1'b0;
    logic        issue_ready_out;
    logic [2:0]  exec_unit_sel_in = 3'b000;
    logic [3:0]  exec_uop_in = 4'h0;
    logic [2:0]  unit_valid_out;
    logic [2:0]  unit_ready_in = 3'b000;
    logic [11:0] unit_uop_out;
    logic [5:0]  unit_issue_cnt_out;
    logic        illegal_sel_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [2:0]  uv;
        logic [11:0] uop;
        logic [5:0]  cnt;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];

    issue_dispatch_unit #(
        .NUM_UNITS (3),
        .UOP_W     (4),
        .CNT_W     (2)
    ) dut (
        .clock_in           (clock_in),
        .reset_in           (reset_in),
        .flush_in           (flush_in),
        .issue_valid_in     (issue_valid_in),
        .issue_ready_out    (issue_ready_out),
        .exec_unit_sel_in   (exec_unit_sel_in),
        .exec_uop_in        (exec_uop_in),
        .unit_valid_out     (unit_valid_out),
        .unit_ready_in      (unit_ready_in),
        .unit_uop_out       (unit_uop_out),
        .unit_issue_cnt_out (unit_issue_cnt_out),
        .illegal_sel_out    (illegal_sel_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: compare the registered outputs after each edge against the queue
    always @(negedge clock_in) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".valid"}, {9'd0, unit_valid_out}, {9'd0, e.uv});
            chk({e.name, ".uop"},   unit_uop_out, e.uop);
            chk({e.name, ".cnt"},   {6'd0, unit_issue_cnt_out}, {6'd0, e.cnt});
            chk({e.name, ".ill"},   {11'd0, illegal_sel_out}, {11'd0, e.ill});
        end
    end

    // One clock of stimulus; expected state after the coming edge is queued
    task automatic cycle(input string nm, input bit rel, input bit v, input logic [2:0] sel,
                         input logic [3:0] uop, input logic [2:0] rdy, input bit fl,
                         input bit exp_irdy, input logic [2:0] euv, input logic [11:0] euop,
                         input logic [5:0] ecnt, input bit eill);
        exp_t e;
        @(negedge clock_in);
        #1;
        if (rel) reset_in = 1'b0;
        issue_valid_in   = v;
        exec_unit_sel_in = sel;
        exec_uop_in      = uop;
        unit_ready_in    = rdy;
        flush_in         = fl;
        #1;
        chk({nm, ".ready"}, {11'd0, issue_ready_out}, {11'd0, exp_irdy});
        e.name = nm; e.uv = euv; e.uop = euop; e.cnt = ecnt; e.ill = eill;
        exp_q.push_back(e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        chk("rst.valid", {9'd0, unit_valid_out}, 12'd0);
        chk("rst.uop",   unit_uop_out, 12'd0);
        chk("rst.cnt",   {6'd0, unit_issue_cnt_out}, 12'd0);
        chk("rst.ill",   {11'd0, illegal_sel_out}, 12'd0);

        //    name      rel v  sel     uop   rdy     fl irdy uv      uop     cnt        ill
        cycle("load5",  1, 1, 3'b001, 4'h5, 3'b000, 0, 1, 3'b001, 12'h005, 6'b000000, 1'b0);
        cycle("stall",  0, 0, 3'b001, 4'h0, 3'b000, 0, 0, 3'b001, 12'h005, 6'b000000, 1'b0);
        cycle("nobub",  0, 1, 3'b001, 4'h9, 3'b001, 0, 1, 3'b001, 12'h009, 6'b000001, 1'b0);
        cycle("indep",  0, 1, 3'b100, 4'h3, 3'b000, 0, 1, 3'b101, 12'h309, 6'b000001, 1'b0);
        cycle("ill011", 0, 1, 3'b011, 4'h7, 3'b000, 0, 1, 3'b101, 12'h309, 6'b000001, ILL_EN);
        cycle("sel000", 0, 0, 3'b000, 4'h0, 3'b000, 0, 1, 3'b101, 12'h309, 6'b000001, ILL_EN);
        cycle("flush",  0, 1, 3'b010, 4'h6, 3'b001, 1, 0, 3'b000, 12'h000, 6'b000010, 1'b0);
        cycle("vec1",   0, 1, 3'b010, 4'h1, 3'b000, 0, 1, 3'b010, 12'h010, 6'b000010, 1'b0);
        cycle("vec2",   0, 1, 3'b010, 4'h2, 3'b010, 0, 1, 3'b010, 12'h020, 6'b000110, 1'b0);
        cycle("vec3",   0, 1, 3'b010, 4'h3, 3'b010, 0, 1, 3'b010, 12'h030, 6'b001010, 1'b0);
        cycle("vec4",   0, 1, 3'b010, 4'h4, 3'b010, 0, 1, 3'b010, 12'h040, 6'b001110, 1'b0);
        cycle("vecwrp", 0, 1, 3'b010, 4'h5, 3'b010, 0, 1, 3'b010, 12'h050, 6'b000010, 1'b0);
        cycle("vecdrn", 0, 0, 3'b000, 4'h0, 3'b010, 0, 1, 3'b000, 12'h000, 6'b000110, 1'b0);
        cycle("intA",   0, 1, 3'b001, 4'hA, 3'b000, 0, 1, 3'b001, 12'h00A, 6'b000110, 1'b0);
        cycle("lsuC",   0, 1, 3'b100, 4'hC, 3'b000, 0, 1, 3'b101, 12'hC0A, 6'b000110, 1'b0);
        cycle("intblk", 0, 1, 3'b001, 4'hB, 3'b000, 0, 0, 3'b101, 12'hC0A, 6'b000110, 1'b0);

        // Asynchronous reset between edges with slots full
        @(negedge clock_in);
        #1;
        issue_valid_in = 1'b0;
        reset_in       = 1'b1;
        #1;
        chk("arst.valid", {9'd0, unit_valid_out}, 12'd0);
        chk("arst.uop",   unit_uop_out, 12'd0);
        chk("arst.cnt",   {6'd0, unit_issue_cnt_out}, 12'd0);
        chk("arst.ill",   {11'd0, illegal_sel_out}, 12'd0);

        cycle("postrst", 1, 1, 3'b010, 4'hF, 3'b000, 0, 1, 3'b010, 12'h0F0, 6'b000000, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock_in);
        @(posedge clock_in);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_dispatch_unit.md
ISSUE_DISPATCH_UNIT -- requirements
Module: issue_dispatch_unit

Interface
REQ-001 Parameter NUM_UNITS, default 3: number of execution units (1..8); sel bit 0 = INT, 1 = VEC, 2 = LSU.
REQ-002 Parameter UOP_W, default 4: micro-op width in bits.
REQ-003 Parameter CNT_W, default 16: width of each per-unit issue counter.
REQ-004 clock_in  input  1: single clock; all state updates on its rising edge.
REQ-005 reset_in  input  1: asynchronous, active-high reset.
REQ-006 flush_in  input  1: synchronous flush of all pending micro-ops.
REQ-007 issue_valid_in  input  1: upstream micro-op valid.
REQ-008 issue_ready_out  output  1: dispatch can accept this cycle.
REQ-009 exec_unit_sel_in  input  NUM_UNITS: one-hot target unit select.
REQ-010 exec_uop_in  input  UOP_W: micro-op.
REQ-011 unit_valid_out  output  NUM_UNITS: per-unit slot valid.
REQ-012 unit_ready_in  input  NUM_UNITS: per-unit consume strobe.
REQ-013 unit_uop_out  output  NUM_UNITS*UOP_W: per-unit micro-op; unit k occupies bits [k*UOP_W +: UOP_W].
REQ-014 unit_issue_cnt_out  output  NUM_UNITS*CNT_W: per-unit issued-op counters, same packing as REQ-013.
REQ-015 illegal_sel_out  output  1: sticky illegal-select flag.

Function
REQ-016 Each unit k SHALL own a one-entry slot: a valid bit and a UOP_W register.
REQ-017 Drain: slot k SHALL empty when unit_valid_out[k] && unit_ready_in[k].
REQ-018 sel legal = exactly one bit set; issue_ready_out SHALL be 1 when sel is illegal; otherwise !slot_valid[k] || unit_ready_in[k] for selected k; forced 0 while flush_in = 1.
REQ-019 Accept = issue_valid_in && issue_ready_out && sel legal; slot k SHALL load exec_uop_in and set valid on that edge; latency input to unit output = 1 cycle.
REQ-020 Simultaneous drain and load of slot k SHALL leave valid = 1 holding the new micro-op, with no bubble.
REQ-021 unit_uop_out for a slot with valid = 0 SHALL read all zeros.
REQ-022 Illegal select with issue_valid_in = 1 (zero bits or several bits set) SHALL be consumed and dropped; no slot or counter changes.
REQ-023 unit_issue_cnt_out[k] SHALL increment by 1 on every drain of slot k, wrapping from 2^CNT_W-1 to 0.
REQ-024 flush_in = 1 SHALL clear all slot valids and zero slot micro-ops on the next edge; drains in that cycle still count; counters are otherwise kept.
REQ-025 Slots for different units SHALL operate independently; backpressure on one unit SHALL NOT block issue to another.

Reset
REQ-026 reset_in = 1 SHALL immediately force all slot valids to 0, micro-ops to 0, counters to 0, and illegal_sel_out to 0.
REQ-027 Reset mid-transfer SHALL discard pending micro-ops; first accept is possible on the first clock edge after release.

Configuration
REQ-028 Macro ISSUE_ILLEGAL_SEL_DETECT_EN defined: illegal_sel_out SHALL set on any illegal select with issue_valid_in = 1, and clear only on reset_in or flush_in.
REQ-029 Macro ISSUE_ILLEGAL_SEL_DETECT_EN undefined: illegal_sel_out SHALL be tied 0; drop behaviour per REQ-022 is unchanged.

Structure
REQ-030 The shared package SHALL hold unit index constants (INT = 0, VEC = 1, LSU = 2) and default UOP_W and CNT_W values.
REQ-031 The per-unit slot plus counter SHALL be sub-module issue_slot, instantiated NUM_UNITS times with a generate loop.

Verification (NUM_UNITS = 3, UOP_W = 4)
REQ-032 sel = 001, uop = 0x5, valid for 1 cycle, unit_ready_in = 000 -> next cycle unit_valid_out = 001, INT uop = 0x5, others 0; issue_ready_out = 0 for sel = 001.
REQ-033 INT slot full, unit_ready_in = 001, new uop 0x9 to INT -> uop 0x9 valid the next cycle with no bubble; INT counter = 1.
REQ-034 INT slot full and stalled, uop 0x3 to sel = 100 -> accepted; LSU slot valid next cycle.
REQ-035 sel = 011 with valid -> dropped and issue_ready_out = 1; illegal_sel_out = 1 with the macro and 0 without; flush_in then clears the flag.
REQ-036 CNT_W = 2, 5 drains on the VEC slot -> VEC counter reads 1 (wrap).
REQ-037 reset_in asserted between clock edges with slots full -> outputs zero immediately, without a clock edge.
